// File: rtl/hfswr_tx_pkg.sv
// Shared HFSWR transmit definitions: sequencer state encoding, sizing, DAC
// mid-scale constant and the Barker-13 reference code.
package hfswr_tx_pkg;

  localparam int CODE_MAX = 16;
  localparam int DIV_W    = 16;
  localparam int PRI_W    = 24;
  localparam int LEN_W    = 5;

  localparam int                 DAC_W    = 14;
  localparam logic [DAC_W-1:0]   CERO_DAC = 14'h2000;

  localparam logic [CODE_MAX-1:0] BARKER13     = 16'h1F35;
  localparam int                  BARKER13_LEN = 13;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    OFF
  } state_e;

  // Zero length means one chip; anything past the code register is clamped.
  function automatic logic [LEN_W-1:0] sanitize_len(input logic [LEN_W-1:0] len);
    if (len == '0)
      return LEN_W'(1);
    else if (len > LEN_W'(CODE_MAX))
      return LEN_W'(CODE_MAX);
    else
      return len;
  endfunction

  function automatic logic [DIV_W-1:0] sanitize_div(input logic [DIV_W-1:0] div);
    return (div == '0) ? DIV_W'(1) : div;
  endfunction

endpackage

// File: rtl/bpsk_code_gen_if.sv
// Configuration and chip-stream bundle between the pulse controller and the
// code sequencer. BPSK_CODE_GEN_PULSE_CNT_EN adds the pulse_count return.
interface bpsk_code_gen_if;
  import hfswr_tx_pkg::*;

  logic                 enable;
  logic [CODE_MAX-1:0]  code_word;
  logic [LEN_W-1:0]     code_len;
  logic [DIV_W-1:0]     chip_div;
  logic [PRI_W-1:0]     pri;

  logic                 cod;
  logic                 tx_gate;
  logic                 chip_stb;
  logic                 pulse_sync;
  logic                 busy;

`ifdef BPSK_CODE_GEN_PULSE_CNT_EN
  logic [15:0]          pulse_count;

  modport master (
    output enable, code_word, code_len, chip_div, pri,
    input  cod, tx_gate, chip_stb, pulse_sync, busy, pulse_count
  );

  modport slave (
    input  enable, code_word, code_len, chip_div, pri,
    output cod, tx_gate, chip_stb, pulse_sync, busy, pulse_count
  );
`else
  modport master (
    output enable, code_word, code_len, chip_div, pri,
    input  cod, tx_gate, chip_stb, pulse_sync, busy
  );

  modport slave (
    input  enable, code_word, code_len, chip_div, pri,
    output cod, tx_gate, chip_stb, pulse_sync, busy
  );
`endif

endinterface

// File: rtl/chip_timer.sv
// Chip-period divider and chip index for one pulse; flags the first and last
// cycle of each chip and the final cycle of the whole code.
module chip_timer
  import hfswr_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              run_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              chip_first_o,
  output logic              chip_end_o,
  output logic              pulse_last_o
);

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic [LEN_W-1:0] chipIdx_q, chipIdx_d;

  assign chip_first_o = (divCnt_q == '0);
  assign chip_end_o   = (divCnt_q == div_i - DIV_ONE);
  assign pulse_last_o = chip_end_o && (chipIdx_q == len_i - LEN_ONE);

  always_comb begin
    divCnt_d  = divCnt_q;
    chipIdx_d = chipIdx_q;
    if (run_i) begin
      if (chip_end_o) begin
        divCnt_d  = '0;
        chipIdx_d = pulse_last_o ? '0 : chipIdx_q + LEN_ONE;
      end else begin
        divCnt_d  = divCnt_q + DIV_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      divCnt_q  <= '0;
      chipIdx_q <= '0;
    end else begin
      divCnt_q  <= divCnt_d;
      chipIdx_q <= chipIdx_d;
    end
  end

endmodule

// File: rtl/bpsk_code_gen.sv
// Phase-code chip sequencer feeding the BPSK mixer: MSB-first code, chip
// divider and PRI timing. BPSK_CODE_GEN_PULSE_CNT_EN adds a 16-bit pulse counter.
module bpsk_code_gen
  import hfswr_tx_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  bpsk_code_gen_if.slave bus
);

  localparam logic [PRI_W:0]   PRI_INC = (PRI_W+1)'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  state_e              state_q;
  logic [CODE_MAX-1:0] code_q, code_d;
  logic [LEN_W-1:0]    len_q, lenSan;
  logic [DIV_W-1:0]    div_q, divSan;
  logic [PRI_W-1:0]    pri_q, priCnt_q;
  logic [PRI_W:0]      priNext;
  logic                priDone, startPulse;
  logic                chipFirst, chipEnd, pulseLast;
  logic                cod_q, txGate_q, chipStb_q, pulseSync_q, busy_q;

  assign lenSan = sanitize_len(bus.code_len);
  assign divSan = sanitize_div(bus.chip_div);

  // Left-align the code so the current chip is always the register MSB.
  assign code_d = bus.code_word << (LEN_W'(CODE_MAX) - lenSan);

  assign priNext    = {1'b0, priCnt_q} + PRI_INC;
  assign priDone    = priNext >= {1'b0, pri_q};
  assign startPulse = bus.enable &&
                      ((state_q == IDLE) || ((state_q == OFF) && priDone));

  chip_timer u_chip_timer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (startPulse),
    .run_i        (state_q == PULSE),
    .div_i        (div_q),
    .len_i        (len_q),
    .chip_first_o (chipFirst),
    .chip_end_o   (chipEnd),
    .pulse_last_o (pulseLast)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      code_q      <= '0;
      len_q       <= LEN_ONE;
      div_q       <= DIV_ONE;
      pri_q       <= '0;
      priCnt_q    <= '0;
      cod_q       <= 1'b1;
      txGate_q    <= 1'b0;
      chipStb_q   <= 1'b0;
      pulseSync_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cod_q       <= 1'b1;
      txGate_q    <= 1'b0;
      chipStb_q   <= 1'b0;
      pulseSync_q <= 1'b0;
      busy_q      <= (state_q != IDLE);

      case (state_q)
        IDLE: ;
        PULSE: begin
          cod_q       <= code_q[CODE_MAX-1];
          txGate_q    <= 1'b1;
          chipStb_q   <= chipFirst;
          pulseSync_q <= (priCnt_q == '0);
          priCnt_q    <= priNext[PRI_W-1:0];
          if (chipEnd)
            code_q <= code_q << 1;
          if (pulseLast)
            state_q <= OFF;
        end
        OFF: begin
          if (!priDone)
            priCnt_q <= priNext[PRI_W-1:0];
          else if (!bus.enable)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // The configuration is frozen here for the whole repetition.
      if (startPulse) begin
        state_q  <= PULSE;
        code_q   <= code_d;
        len_q    <= lenSan;
        div_q    <= divSan;
        pri_q    <= bus.pri;
        priCnt_q <= '0;
      end
    end
  end

  assign bus.cod        = cod_q;
  assign bus.tx_gate    = txGate_q;
  assign bus.chip_stb   = chipStb_q;
  assign bus.pulse_sync = pulseSync_q;
  assign bus.busy       = busy_q;

`ifdef BPSK_CODE_GEN_PULSE_CNT_EN
  logic [15:0] pulseCnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      pulseCnt_q <= '0;
    else if ((state_q == PULSE) && (priCnt_q == '0))
      pulseCnt_q <= pulseCnt_q + 16'd1;
  end

  assign bus.pulse_count = pulseCnt_q;
`endif

endmodule

// File: tb/tb_bpsk_code_gen.sv
// Bench for bpsk_code_gen: per-cycle comparison against a pulse-sequence
// model, directed scenarios with literal expectations, then random traffic.
module tb_bpsk_code_gen;
  import hfswr_tx_pkg::*;

  typedef struct packed {
    logic cod;
    logic gate;
    logic stb;
    logic sync;
    logic busy;
  } outVec_t;

  localparam outVec_t IDLE_V = 5'b10000;

  logic clk;
  logic rst;
  bpsk_code_gen_if bus ();

  bpsk_code_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  outVec_t     expQ[$];
  outVec_t     expOut = IDLE_V;
  logic [15:0] expCount = '0;
  bit          modelValid = 0;

  int          cycleCnt = 0;
  int          gateRun = 0, stbRun = 0, lastGateLen = 0, lastStbCount = 0;
  logic [15:0] bitsRun = '0, lastBits = '0;
  int          pulsesDone = 0, syncCount = 0, syncPeriod = 0, lastSyncCycle = 0;

  // Expand one repetition into the exact output sequence it must produce.
  task automatic buildPulse(input logic [15:0] word, input int lenIn,
                            input int divIn, input int priIn);
    int len, div, onLen, period;
    outVec_t v;
    len    = (lenIn == 0) ? 1 : ((lenIn > CODE_MAX) ? CODE_MAX : lenIn);
    div    = (divIn == 0) ? 1 : divIn;
    onLen  = len * div;
    period = (priIn > onLen) ? priIn : onLen + 1;
    for (int k = 0; k < period; k++) begin
      if (k < onLen) begin
        v.cod  = word[len - 1 - k / div];
        v.gate = 1'b1;
        v.stb  = ((k % div) == 0);
      end else begin
        v.cod  = 1'b1;
        v.gate = 1'b0;
        v.stb  = 1'b0;
      end
      v.sync = (k == 0);
      v.busy = 1'b1;
      expQ.push_back(v);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      expQ.delete();
      expOut     = IDLE_V;
      expCount   = '0;
      modelValid = 1;
    end else begin
      expOut = (expQ.size() > 0) ? expQ.pop_front() : IDLE_V;
      if (expOut.sync)
        expCount = expCount + 16'd1;
      if (expQ.size() == 0 && bus.enable)
        buildPulse(bus.code_word, int'(bus.code_len), int'(bus.chip_div), int'(bus.pri));
    end
  end

  always @(negedge clk) begin
    outVec_t act;
    act = {bus.cod, bus.tx_gate, bus.chip_stb, bus.pulse_sync, bus.busy};
    cycleCnt++;
    if (modelValid) begin
      checks++;
      if (act !== expOut) begin
        errors++;
        $display("[TB] FAIL outputs cycle %0d: actual cod/gate/stb/sync/busy=%b required %b",
                 cycleCnt, act, expOut);
      end
`ifdef BPSK_CODE_GEN_PULSE_CNT_EN
      checks++;
      if (bus.pulse_count !== expCount) begin
        errors++;
        $display("[TB] FAIL pulse_count cycle %0d: actual %0d required %0d",
                 cycleCnt, bus.pulse_count, expCount);
      end
`endif
    end
    if (bus.pulse_sync === 1'b1) begin
      syncPeriod    = cycleCnt - lastSyncCycle;
      lastSyncCycle = cycleCnt;
      syncCount++;
    end
    if (bus.tx_gate === 1'b1) begin
      gateRun++;
      if (bus.chip_stb === 1'b1) begin
        stbRun++;
        bitsRun = {bitsRun[14:0], bus.cod};
      end
    end else if (gateRun != 0) begin
      lastGateLen  = gateRun;
      lastStbCount = stbRun;
      lastBits     = bitsRun;
      gateRun      = 0;
      stbRun       = 0;
      bitsRun      = '0;
      pulsesDone++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [15:0] word,
                               input logic [4:0] len, input logic [15:0] div,
                               input logic [23:0] pri);
    bus.enable    = en;
    bus.code_word = word;
    bus.code_len  = len;
    bus.chip_div  = div;
    bus.pri       = pri;
  endtask

  task automatic waitSync(input int budget);
    int start, k;
    start = syncCount;
    k = 0;
    while (syncCount == start && k < budget) begin
      tick();
      k++;
    end
    if (syncCount == start) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitSync timeout: actual no pulse_sync required one within %0d cycles", budget);
    end
  endtask

  task automatic waitPulseEnd(input int budget);
    int start, k;
    start = pulsesDone;
    k = 0;
    while (pulsesDone == start && k < budget) begin
      tick();
      k++;
    end
    if (pulsesDone == start) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitPulseEnd timeout: actual gate still open required close within %0d cycles", budget);
    end
  endtask

  task automatic waitUntilStb(input int n, input int budget);
    int k;
    k = 0;
    while (stbRun < n && k < budget) begin
      tick();
      k++;
    end
    if (stbRun < n) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitUntilStb timeout: actual %0d strobes required %0d", stbRun, n);
    end
  endtask

  function automatic int outBits();
    return int'({bus.cod, bus.tx_gate, bus.chip_stb, bus.pulse_sync, bus.busy});
  endfunction

  initial begin
    int s;
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, 5'd0, 16'd0, 24'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_outputs", outBits(), 5'b10000);

    $display("[TB] Barker-13, div 4, pri 100");
    applyStimulus(1'b1, BARKER13, 5'd13, 16'd4, 24'd100);
    tick();
    checkOutput("start_latency_idle", outBits(), 5'b10000);
    tick();
    checkOutput("first_chip_all_flags", outBits(), 5'b11111);
    waitPulseEnd(200);
    checkOutput("barker_gate_len", lastGateLen, 52);
    checkOutput("barker_stb_count", lastStbCount, 13);
    checkOutput("barker_bits", int'(lastBits), 16'h1F35);
    waitSync(200);
    checkOutput("barker_sync_period", syncPeriod, 100);

    $display("[TB] short PRI");
    applyStimulus(1'b1, BARKER13, 5'd13, 16'd4, 24'd20);
    waitSync(200);
    waitSync(200);
    checkOutput("short_pri_period", syncPeriod, 53);
    waitPulseEnd(200);
    checkOutput("short_pri_gate_len", lastGateLen, 52);

    $display("[TB] degenerate config");
    applyStimulus(1'b1, 16'hFFFE, 5'd0, 16'd0, 24'd0);
    waitSync(200);
    waitSync(200);
    waitSync(200);
    checkOutput("degenerate_period", syncPeriod, 2);
    waitPulseEnd(20);
    checkOutput("degenerate_gate_len", lastGateLen, 1);
    checkOutput("degenerate_bits", int'(lastBits), 0);
    checkOutput("degenerate_cod_back", int'(bus.cod), 1);

    $display("[TB] enable dropped mid-pulse");
    applyStimulus(1'b1, BARKER13, 5'd13, 16'd4, 24'd100);
    waitSync(200);
    waitSync(200);
    waitUntilStb(6, 100);
    bus.enable = 1'b0;
    waitPulseEnd(200);
    checkOutput("drop_gate_len", lastGateLen, 52);
    checkOutput("drop_stb_count", lastStbCount, 13);
    checkOutput("drop_bits", int'(lastBits), 16'h1F35);
    s = syncCount;
    repeat (150) tick();
    checkOutput("drop_busy_low", int'(bus.busy), 0);
    checkOutput("drop_no_more_sync", syncCount, s);

    $display("[TB] config change mid-pulse");
    applyStimulus(1'b1, BARKER13, 5'd13, 16'd4, 24'd100);
    waitSync(20);
    waitUntilStb(3, 100);
    bus.code_word = 16'h0000;
    waitPulseEnd(200);
    checkOutput("midchange_current_bits", int'(lastBits), 16'h1F35);
    waitPulseEnd(200);
    checkOutput("midchange_next_bits", int'(lastBits), 0);
    checkOutput("midchange_next_gate_len", lastGateLen, 52);

    $display("[TB] reset mid-pulse");
    bus.code_word = BARKER13;
    waitSync(200);
    waitUntilStb(8, 100);
    rst = 1'b1;
    tick();
    checkOutput("rst_midpulse_outputs", outBits(), 5'b10000);
`ifdef BPSK_CODE_GEN_PULSE_CNT_EN
    checkOutput("rst_pulse_count", int'(bus.pulse_count), 0);
`endif
    rst = 1'b0;
    tick();
    checkOutput("rst_restart_idle", outBits(), 5'b10000);
    tick();
    checkOutput("rst_restart_first_chip", outBits(), 5'b11111);
`ifdef BPSK_CODE_GEN_PULSE_CNT_EN
    checkOutput("rst_restart_pulse_count", int'(bus.pulse_count), 1);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 16'($urandom()),
                    5'($urandom_range(0, 31)), 16'($urandom_range(0, 6)),
                    24'($urandom_range(0, 120)));
      repeat ($urandom_range(1, 200)) tick();
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end
    bus.enable = 1'b0;
    repeat (150) tick();
    checkOutput("final_idle_busy", int'(bus.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual still running required finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
